// File: rtl/xor_stream_decryptor_if.sv
// Byte-stream handshake bundle for the XOR stream decryptor: key load, ciphertext in,
// plaintext out, plus frame status.
interface xor_stream_decryptor_if;
    logic       key_load;
    logic [7:0] key_in;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic [7:0] byte_count;
    logic       key_err;

    modport master (
        output key_load, key_in, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, byte_count, key_err
    );

    modport slave (
        input  key_load, key_in, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, byte_count, key_err
    );
endinterface

// File: rtl/xor_stream_decryptor.sv
// XOR stream decryptor: a Galois LFSR keystream seeded per frame by key_load, XORed onto
// each accepted ciphertext byte into a single-entry registered output stage.
module xor_stream_decryptor #(
    parameter logic [7:0] LFSR_TAPS = 8'hB8
) (
    input logic                     clk,
    input logic                     rst,
    xor_stream_decryptor_if.slave   bus
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e     state_q, state_d;
    logic [7:0] ks_q, ks_d;
    logic [7:0] out_data_q, out_data_d;
    logic [7:0] byte_count_q, byte_count_d;
    logic       out_valid_q, out_valid_d;
    logic       out_last_q, out_last_d;
    logic       key_err_q, key_err_d;
    logic       in_ready;
    logic       accept;

    always_comb begin
        state_d      = state_q;
        ks_d         = ks_q;
        out_data_d   = out_data_q;
        byte_count_d = byte_count_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        key_err_d    = key_err_q;

        // Output register frees up either when empty or when drained this cycle.
        in_ready = (state_q == StRun) && (!out_valid_q || bus.out_ready);
        accept   = bus.in_valid && in_ready;

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.in_data ^ ks_q;
            out_last_d  = bus.in_last;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.key_load) begin
                    // An all-zero seed would lock the LFSR, so substitute 1.
                    ks_d         = (bus.key_in == 8'h00) ? 8'h01 : bus.key_in;
                    byte_count_d = 8'h00;
                    key_err_d    = 1'b0;
                    state_d      = StRun;
                end
            end
            StRun: begin
                if (bus.key_load) begin
                    key_err_d = 1'b1;
                end
                if (accept) begin
                    ks_d         = (ks_q >> 1) ^ (ks_q[0] ? LFSR_TAPS : 8'h00);
                    byte_count_d = byte_count_q + 8'd1;
                    if (bus.in_last) begin
                        state_d = StIdle;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            ks_q         <= 8'h01;
            out_data_q   <= 8'h00;
            byte_count_q <= 8'h00;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            key_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ks_q         <= ks_d;
            out_data_q   <= out_data_d;
            byte_count_q <= byte_count_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            key_err_q    <= key_err_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_last   = out_last_q;
    assign bus.byte_count = byte_count_q;
    assign bus.key_err    = key_err_q;

endmodule

// File: tb/tb_xor_stream_decryptor.sv
// Directed bench for xor_stream_decryptor: a table of per-byte vectors plus hand-written
// sequences for backpressure, key errors, counter wrap and mid-frame reset.
module tb_xor_stream_decryptor;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    xor_stream_decryptor_if ifc ();

    xor_stream_decryptor #(
        .LFSR_TAPS (8'hB8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       new_frame;
        logic [7:0] key;
        logic [7:0] din;
        logic       last;
        logic [7:0] dout;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] next_ks(input logic [7:0] ks);
        return (ks >> 1) ^ (ks[0] ? 8'hB8 : 8'h00);
    endfunction

    // Called at posedge+1; leaves the bench at posedge+1 after the load edge.
    task automatic load_key(input logic [7:0] k);
        ifc.key_load = 1'b1;
        ifc.key_in   = k;
        @(posedge clk);
        #1;
        ifc.key_load = 1'b0;
    endtask

    // Presents one byte until accepted (bounded); returns at posedge+1 after the accept edge.
    task automatic send_byte(input logic [7:0] d, input logic last);
        logic ok;
        ok           = 1'b0;
        ifc.in_valid = 1'b1;
        ifc.in_data  = d;
        ifc.in_last  = last;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (ifc.in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got no in_ready expected accept (t=%0t)", $time);
        end
    endtask

    initial begin
        logic [7:0] ks;
        int         frame_len;

        n_cmp = 0;
        n_err = 0;
        vecs[0] = '{1'b1, 8'h5A, 8'h00, 1'b0, 8'h5A};
        vecs[1] = '{1'b0, 8'h5A, 8'h2D, 1'b0, 8'h00};
        vecs[2] = '{1'b0, 8'h5A, 8'h00, 1'b1, 8'hAE};
        vecs[3] = '{1'b1, 8'h00, 8'hFF, 1'b1, 8'hFE};
        vecs[4] = '{1'b1, 8'h01, 8'h41, 1'b0, 8'h40};
        vecs[5] = '{1'b0, 8'h01, 8'h00, 1'b1, 8'hB8};
        vecs[6] = '{1'b1, 8'hB8, 8'h11, 1'b0, 8'hA9};
        vecs[7] = '{1'b0, 8'hB8, 8'h5C, 1'b0, 8'h00};
        vecs[8] = '{1'b0, 8'hB8, 8'hFF, 1'b1, 8'hD1};

        ifc.key_load  = 1'b0;
        ifc.key_in    = 8'h00;
        ifc.in_valid  = 1'b0;
        ifc.in_data   = 8'h00;
        ifc.in_last   = 1'b0;
        ifc.out_ready = 1'b1;
        rst           = 1'b1;
        #12;
        chk("rst_out_valid", 32'(ifc.out_valid), 32'h0);
        chk("rst_out_data", 32'(ifc.out_data), 32'h0);
        chk("rst_out_last", 32'(ifc.out_last), 32'h0);
        chk("rst_byte_count", 32'(ifc.byte_count), 32'h0);
        chk("rst_key_err", 32'(ifc.key_err), 32'h0);
        chk("rst_in_ready", 32'(ifc.in_ready), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // in_valid while IDLE must not consume anything
        ifc.in_valid = 1'b1;
        ifc.in_data  = 8'h77;
        ifc.in_last  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_in_ready", 32'(ifc.in_ready), 32'h0);
        end
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
        chk("idle_out_valid", 32'(ifc.out_valid), 32'h0);
        chk("idle_byte_count", 32'(ifc.byte_count), 32'h0);

        // Table-driven frames, out_ready held high
        frame_len = 0;
        foreach (vecs[i]) begin
            if (vecs[i].new_frame) begin
                load_key(vecs[i].key);
                frame_len = 0;
            end
            send_byte(vecs[i].din, vecs[i].last);
            frame_len++;
            chk($sformatf("vec%0d_valid", i), 32'(ifc.out_valid), 32'h1);
            chk($sformatf("vec%0d_data", i), 32'(ifc.out_data), 32'(vecs[i].dout));
            chk($sformatf("vec%0d_last", i), 32'(ifc.out_last), 32'(vecs[i].last));
            if (vecs[i].last) begin
                chk($sformatf("vec%0d_count", i), 32'(ifc.byte_count), 32'(frame_len));
                chk($sformatf("vec%0d_idle", i), 32'(ifc.in_ready), 32'h0);
            end
        end
        @(posedge clk);
        #1;
        chk("drain_out_valid", 32'(ifc.out_valid), 32'h0);

        // Backpressure: hold out_ready low, then drain and accept in the same cycle
        ifc.out_ready = 1'b0;
        load_key(8'h5A);
        send_byte(8'h00, 1'b0);
        ifc.in_valid = 1'b1;
        ifc.in_data  = 8'h2D;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(ifc.in_ready), 32'h0);
            chk("bp_out_valid", 32'(ifc.out_valid), 32'h1);
            chk("bp_out_data", 32'(ifc.out_data), 32'h5A);
            @(posedge clk);
            #1;
        end
        ifc.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(ifc.in_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("bp_swap_valid", 32'(ifc.out_valid), 32'h1);
        chk("bp_swap_data", 32'(ifc.out_data), 32'h00);
        chk("bp_swap_count", 32'(ifc.byte_count), 32'h2);
        ifc.in_data = 8'h00;
        ifc.in_last = 1'b1;
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
        chk("bp_third_data", 32'(ifc.out_data), 32'hAE);
        chk("bp_third_last", 32'(ifc.out_last), 32'h1);
        chk("bp_third_count", 32'(ifc.byte_count), 32'h3);
        @(posedge clk);
        #1;
        chk("bp_final_drain", 32'(ifc.out_valid), 32'h0);

        // key_load during RUN alongside an accept
        load_key(8'h5A);
        send_byte(8'h00, 1'b0);
        chk("kerr_b0", 32'(ifc.out_data), 32'h5A);
        ifc.key_load = 1'b1;
        ifc.key_in   = 8'h33;
        ifc.in_valid = 1'b1;
        ifc.in_data  = 8'h2D;
        @(posedge clk);
        #1;
        ifc.key_load = 1'b0;
        ifc.in_valid = 1'b0;
        chk("kerr_b1", 32'(ifc.out_data), 32'h00);
        chk("kerr_set", 32'(ifc.key_err), 32'h1);
        send_byte(8'h00, 1'b1);
        chk("kerr_b2", 32'(ifc.out_data), 32'hAE);
        chk("kerr_sticky", 32'(ifc.key_err), 32'h1);
        load_key(8'h77);
        chk("kerr_clear", 32'(ifc.key_err), 32'h0);
        send_byte(8'h00, 1'b1);
        chk("kerr_new_seed", 32'(ifc.out_data), 32'h77);

        // 256-byte zero frame: output is the raw keystream, counter wraps
        load_key(8'hA5);
        ks = 8'hA5;
        for (int i = 0; i < 256; i++) begin
            send_byte(8'h00, (i == 255));
            chk($sformatf("long_%0d", i), 32'(ifc.out_data), 32'(ks));
            ks = next_ks(ks);
            if (i == 254) chk("long_count_ff", 32'(ifc.byte_count), 32'hFF);
        end
        chk("long_count_wrap", 32'(ifc.byte_count), 32'h00);
        chk("long_last", 32'(ifc.out_last), 32'h1);
        chk("long_idle", 32'(ifc.in_ready), 32'h0);

        // Reset mid-frame with a pending output byte
        @(posedge clk);
        #1;
        ifc.out_ready = 1'b0;
        load_key(8'h5A);
        send_byte(8'h00, 1'b0);
        chk("mrst_pending", 32'(ifc.out_valid), 32'h1);
        rst = 1'b1;
        #1;
        chk("mrst_out_valid", 32'(ifc.out_valid), 32'h0);
        chk("mrst_out_data", 32'(ifc.out_data), 32'h0);
        chk("mrst_byte_count", 32'(ifc.byte_count), 32'h0);
        chk("mrst_in_ready", 32'(ifc.in_ready), 32'h0);
        @(posedge clk);
        #1;
        rst           = 1'b0;
        ifc.out_ready = 1'b1;
        ifc.in_valid  = 1'b1;
        ifc.in_data   = 8'h33;
        repeat (3) @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        chk("mrst_ignored_valid", 32'(ifc.out_valid), 32'h0);
        chk("mrst_ignored_count", 32'(ifc.byte_count), 32'h0);
        load_key(8'h00);
        send_byte(8'hFF, 1'b1);
        chk("mrst_restart_data", 32'(ifc.out_data), 32'hFE);
        chk("mrst_restart_last", 32'(ifc.out_last), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
